// File: rtl/shift_exu_pkg.sv
// Shared definitions for the execute-stage shift unit.
// Holds the 3-bit op-code constants, the FSM state type and a rotate-decode helper.
package shift_exu_pkg;

  localparam logic [2:0] SHIFT_OP_SLL = 3'd0;
  localparam logic [2:0] SHIFT_OP_SRL = 3'd1;
  localparam logic [2:0] SHIFT_OP_SRA = 3'd2;
  localparam logic [2:0] SHIFT_OP_ROL = 3'd3;
  localparam logic [2:0] SHIFT_OP_ROR = 3'd4;

  localparam int unsigned SHIFT_WORD_LEN = 32;

  typedef enum logic {
    SHIFT_ST_IDLE = 1'b0,
    SHIFT_ST_ROT  = 1'b1
  } shift_state_e;

  function automatic logic shift_is_rotate(input logic [2:0] op);
    return (op == SHIFT_OP_ROL) || (op == SHIFT_OP_ROR);
  endfunction

endpackage

// File: rtl/shift_exu_buck_shift.sv
// buck_shift: combinational barrel shifter shared by every pass of the shift unit.
// Ports:
//   data_i   - value to shift
//   shamt_i  - shift amount
//   left_i   - 1: shift left, 0: shift right
//   arith_i  - right shifts replicate the sign bit when set
//   data_o   - shifted value
module buck_shift #(
  parameter int unsigned DATA_LEN  = 64,
  parameter int unsigned SHAMT_LEN = 6
) (
  input  logic [DATA_LEN-1:0]  data_i,
  input  logic [SHAMT_LEN-1:0] shamt_i,
  input  logic                 left_i,
  input  logic                 arith_i,
  output logic [DATA_LEN-1:0]  data_o
);

  always_comb begin
    data_o = '0;
    if (left_i) begin
      data_o = data_i << shamt_i;
    end else if (arith_i) begin
      data_o = $unsigned($signed(data_i) >>> shamt_i);
    end else begin
      data_o = data_i >> shamt_i;
    end
  end

endmodule

// File: rtl/shift_exu.sv
// shift_exu: RV64 execute-stage shift/rotate unit.
// Single-pass ops (shifts, word rotates, reserved) produce a result one cycle after
// accept; 64-bit rotates take a second pass through the same shifter (state ROT).
// Ports:
//   clk, rst_n (sync, active-low), flush (kills pending and in-flight results)
//   in_valid/in_ready/in_op/in_word/in_src1/in_shamt/in_rd - issue handshake
//   out_valid/out_ready/out_data/out_rd                    - registered writeback result
module shift_exu
  import shift_exu_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 64,
  parameter int unsigned SHAMT_LEN = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic                 in_word,
  input  logic [DATA_LEN-1:0]  in_src1,
  input  logic [SHAMT_LEN-1:0] in_shamt,
  input  logic [4:0]           in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_LEN-1:0]  out_data,
  output logic [4:0]           out_rd
);

  localparam int unsigned WL = SHIFT_WORD_LEN;

  shift_state_e         state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0]  out_data_q, out_data_d;
  logic [4:0]           out_rd_q, out_rd_d;
  logic [DATA_LEN-1:0]  rot_part_q, rot_part_d;
  logic [DATA_LEN-1:0]  rot_src_q, rot_src_d;
  logic [SHAMT_LEN-1:0] rot_shamt_q, rot_shamt_d;
  logic                 rot_left_q, rot_left_d;
  logic [4:0]           rot_rd_q, rot_rd_d;

  logic                 accept;
  logic                 rot64;
  logic [WL-1:0]        src_w;
  logic [SHAMT_LEN-1:0] shamt_w;
  logic [DATA_LEN-1:0]  sh_data, sh_res, single_res;
  logic [SHAMT_LEN-1:0] sh_amt;
  logic                 sh_left, sh_arith;

  assign in_ready = rst_n && !flush && (state_q == SHIFT_ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign rot64    = shift_is_rotate(in_op) && !in_word;
  assign src_w    = in_src1[WL-1:0];
  assign shamt_w  = {{(SHAMT_LEN-5){1'b0}}, in_shamt[4:0]};

  // Shifter operand mux: the incoming op in IDLE, the latched rotate in ROT.
  always_comb begin
    sh_data  = in_src1;
    sh_amt   = in_shamt;
    sh_left  = (in_op == SHIFT_OP_SLL) || (in_op == SHIFT_OP_ROL);
    sh_arith = (in_op == SHIFT_OP_SRA);
    if (state_q == SHIFT_ST_ROT) begin
      // Second half of the rotate: opposite direction by (DATA_LEN - n) mod DATA_LEN.
      sh_data  = rot_src_q;
      sh_amt   = '0 - rot_shamt_q;
      sh_left  = !rot_left_q;
      sh_arith = 1'b0;
    end else if (in_word) begin
      sh_amt = shamt_w;
      case (in_op)
        SHIFT_OP_SRL: sh_data = {{(DATA_LEN-WL){1'b0}}, src_w};
        SHIFT_OP_SRA: sh_data = {{(DATA_LEN-WL){src_w[WL-1]}}, src_w};
        // Doubled word: the rotated value lands in the low (ROR) or high (ROL) half.
        SHIFT_OP_ROL,
        SHIFT_OP_ROR: sh_data = {{(DATA_LEN-2*WL){1'b0}}, src_w, src_w};
        default:      sh_data = in_src1;
      endcase
    end
  end

  buck_shift #(
    .DATA_LEN (DATA_LEN),
    .SHAMT_LEN(SHAMT_LEN)
  ) u_buck_shift (
    .data_i (sh_data),
    .shamt_i(sh_amt),
    .left_i (sh_left),
    .arith_i(sh_arith),
    .data_o (sh_res)
  );

  always_comb begin
    single_res = sh_res;
    if (in_op > SHIFT_OP_ROR) begin
      single_res = '0;
    end else if (in_word) begin
      if (in_op == SHIFT_OP_ROL) begin
        single_res = {{(DATA_LEN-WL){sh_res[2*WL-1]}}, sh_res[2*WL-1:WL]};
      end else begin
        single_res = {{(DATA_LEN-WL){sh_res[WL-1]}}, sh_res[WL-1:0]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    rot_part_d  = rot_part_q;
    rot_src_d   = rot_src_q;
    rot_shamt_d = rot_shamt_q;
    rot_left_d  = rot_left_q;
    rot_rd_d    = rot_rd_q;
    if (flush) begin
      state_d     = SHIFT_ST_IDLE;
      out_valid_d = 1'b0;
      rot_part_d  = '0;
      rot_src_d   = '0;
      rot_shamt_d = '0;
      rot_left_d  = 1'b0;
      rot_rd_d    = '0;
    end else if (state_q == SHIFT_ST_ROT) begin
      // Output register is free here: entering ROT required it to drain.
      state_d     = SHIFT_ST_IDLE;
      out_valid_d = 1'b1;
      out_data_d  = sh_res | rot_part_q;
      out_rd_d    = rot_rd_q;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (rot64) begin
          state_d     = SHIFT_ST_ROT;
          rot_part_d  = sh_res;
          rot_src_d   = in_src1;
          rot_shamt_d = in_shamt;
          rot_left_d  = (in_op == SHIFT_OP_ROL);
          rot_rd_d    = in_rd;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = single_res;
          out_rd_d    = in_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SHIFT_ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      rot_part_q  <= '0;
      rot_src_q   <= '0;
      rot_shamt_q <= '0;
      rot_left_q  <= 1'b0;
      rot_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      rot_part_q  <= rot_part_d;
      rot_src_q   <= rot_src_d;
      rot_shamt_q <= rot_shamt_d;
      rot_left_q  <= rot_left_d;
      rot_rd_q    <= rot_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;

endmodule

// File: doc/shift_exu.md
# shift_exu

Execute-stage shift unit for the RV64 integer pipeline. It accepts shift and rotate micro-ops from issue over a valid/ready handshake and produces a registered, tagged result for writeback. Each operation drives a single `buck_shift` barrel-shifter instance. Word (`*W`) variants take one pass. 64-bit rotates use two passes through the same shifter, sequenced by a small FSM.

## Interface
- `DATA_LEN`, 64, operand and result width.
- `SHAMT_LEN`, 6, shift-amount width (log2 `DATA_LEN`).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `flush` input 1: pipeline kill; discards in-flight and pending results.
- `in_valid` input 1: issue offers an op.
- `in_ready` output 1: unit accepts an op this cycle.
- `in_op` input 3: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 reserved.
- `in_word` input 1: word variant (32-bit operate, result sign-extended).
- `in_src1` input `DATA_LEN`: value to shift.
- `in_shamt` input `SHAMT_LEN`: shift amount. Word ops use bits [4:0] only.
- `in_rd` input 5: destination tag, passed through unchanged.
- `out_valid` output 1: result available.
- `out_ready` input 1: writeback consumes the result.
- `out_data` output `DATA_LEN`: result.
- `out_rd` output 5: tag of the result.

## Operation
- Accept when `in_valid && in_ready`. `in_ready` = `rst_n && !flush && state==IDLE && (!out_valid || out_ready)`.
- Single-pass ops: all non-rotate ops, plus rotates with `in_word`=1.
  - SLL: `src1 << n`.
  - SRL, SRA: logical or arithmetic right shift.
  - SLLW: shift, then sign-extend bit 31.
  - SRLW: zero-extend `src1[31:0]` to 64 bits, shift right, sign-extend bit 31.
  - SRAW: sign-extend `src1[31:0]`, shift right arithmetic, sign-extend bit 31.
  - RORW: `{x32,x32} >> n`, take low 32, sign-extend.
  - ROLW: `{x32,x32} << n`, take high 32, sign-extend.
- 64-bit rotate (op 3/4, `in_word`=0) uses two passes:
  - Pass 1 (accept cycle): shift `src1` by `n` (ROL left, ROR right). Latch partial result, `src1`, and `n`.
  - Pass 2 (state ROT): shift the latched `src1` the opposite direction by `(64-n) mod 64`, then OR with the partial result.
  - n=0 wraps to a 0 shift, giving `src1|src1 = src1`. This is correct and needs no special case.
- Reserved op: completes in one pass with `out_data`=0.
- FSM states:
  - IDLE → ROT on accepting a 64-bit rotate.
  - ROT → IDLE after one cycle, loading the output register.
  - Output register is loaded only when `!out_valid || out_ready`, which holds by construction of `in_ready`.
- Shifter mux: one `buck_shift` instance. Its input, amount, and direction/arith selects come from the incoming op in IDLE and from the latched rotate state in ROT.

## Timing
- Reset (`rst_n`=0 at edge): state=IDLE, `out_valid`=0, `out_data`=0, `out_rd`=0, internal rotate latches=0. `in_ready`=0 while `rst_n`=0.
- Latency, accept edge to `out_valid`:
  - Single-pass ops: 1 cycle.
  - 64-bit rotate: 2 cycles. `in_ready`=0 during ROT.
- Throughput: 1 op/cycle for single-pass ops when `out_ready`=1. 64-bit rotates issue 1 per 2 cycles.
- Backpressure: `out_valid` stays high, and `out_data`/`out_rd` stay stable, until `out_ready`. Accept and drain can occur in the same cycle.
- `flush`=1 at an edge: `out_valid`←0, state←IDLE, rotate latches discarded. Same-cycle `in_valid` is not accepted. `flush` has priority over every other event.
- A reset mid-rotate behaves like a flush plus output zeroing.

## Structure
- Shared package holds:
  - Op-code constants `SHIFT_OP_SLL`/`SRL`/`SRA`/`ROL`/`ROR` (3 bits).
  - FSM state constants `SHIFT_ST_IDLE`/`SHIFT_ST_ROT`.
- One sub-module: `buck_shift` with `DATA_LEN`, `SHAMT_LEN`, instantiated exactly once.
- Target: about 150–250 lines of RTL.

## Test plan
- SRAW: `src1`=0x0000_0000_8000_0000, n=4, `in_word`=1 → `out_data`=0xFFFF_FFFF_F800_0000 one cycle after accept.
- ROR 64-bit: `src1`=0x0000_0000_0000_0001, n=1 → `out_data`=0x8000_0000_0000_0000 two cycles after accept. `in_ready`=0 in the ROT cycle.
- ROL n=0: `src1`=0x1234_5678_9ABC_DEF0 → output equals input.
- ROLW: `src1`=0xFFFF_FFFF_8000_0001, n=4 → 0x0000_0000_0000_0018.
- Backpressure: `out_ready`=0 for 3 cycles after an SLL result →
  - `out_valid`, `out_data`, `out_rd` held.
  - `in_ready`=0 throughout.
  - Back-to-back accept resumes the cycle `out_ready` rises.
- Flush during ROT, with `in_valid`=1 in the same cycle → no output. Next cycle: `in_ready`=1, state IDLE. A following SRL 0xF0 by 4 yields 0x0F.
